// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus receive path: FSM state encoding,
// sampling phase encoding, default sizing and the running-XOR helper.
package maple_pkg;

  // One-hot receive FSM state encoding
  typedef enum logic [2:0] {
    MAPLE_RX_IDLE = 3'b001,
    MAPLE_RX_RECV = 3'b010,
    MAPLE_RX_DONE = 3'b100
  } maple_rx_state_e;

  // Which data line's falling edge samples the next bit
  typedef enum logic {
    MAPLE_PHASE_A = 1'b0,
    MAPLE_PHASE_B = 1'b1
  } maple_phase_e;

  localparam int MAPLE_MAX_BYTES_DEFAULT      = 1024;
  localparam int MAPLE_TIMEOUT_CYCLES_DEFAULT = 4096;
  localparam int MAPLE_CNT_W_DEFAULT          = 11;

  // Longitudinal redundancy check: fold one more byte into the running XOR
  function automatic logic [7:0] maple_lrc_next(input logic [7:0] lrc, input logic [7:0] data);
    return lrc ^ data;
  endfunction

endpackage

// File: rtl/maple_byte_assembler.sv
// Maple receive bit/byte assembler. Alternates between sampling SDCKB on an
// SDCKA falling edge (phase A) and SDCKA on an SDCKB falling edge (phase B),
// shifts bits in MSB first and flags the cycle in which the 8th bit arrives.
// byte_ready/byte_data are combinational; the caller registers them.
module maple_byte_assembler
  import maple_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       sdcka_in,
  input  logic       sdckb_in,
  input  logic       sdcka_negedge,
  input  logic       sdckb_negedge,
  output logic       bit_accept,
  output logic       byte_ready,
  output logic [7:0] byte_data
);

  maple_phase_e phase_q, phase_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic         sample_bit_s;

  // Phase tracking, bit sampling and shift/count update
  always_comb begin
    phase_d      = phase_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    bit_accept   = 1'b0;
    sample_bit_s = 1'b0;
    if (clear) begin
      phase_d   = MAPLE_PHASE_A;
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (enable) begin
      case (phase_q)
        MAPLE_PHASE_A: begin
          if (sdcka_negedge) begin
            bit_accept   = 1'b1;
            sample_bit_s = sdckb_in;
            phase_d      = MAPLE_PHASE_B;
          end else begin
            phase_d = MAPLE_PHASE_A;
          end
        end
        MAPLE_PHASE_B: begin
          if (sdckb_negedge) begin
            bit_accept   = 1'b1;
            sample_bit_s = sdcka_in;
            phase_d      = MAPLE_PHASE_A;
          end else begin
            phase_d = MAPLE_PHASE_B;
          end
        end
        default: phase_d = MAPLE_PHASE_A;
      endcase
      if (bit_accept) begin
        shift_d   = {shift_q[6:0], sample_bit_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  assign byte_ready = bit_accept && (bit_cnt_q == 3'd7);
  assign byte_data  = shift_d;

  // Assembler state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= MAPLE_PHASE_A;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/maple_rx_deserializer.sv
// Maple bus receive deserializer. Between a start pulse and an end pulse it
// streams assembled bytes out with rx_valid, then closes the frame with a
// one-cycle frame_done or frame_error pulse and leaves rx_count holding the
// byte count. Define MAPLE_RX_LRC_CHECK_EN to add the rx_lrc running-XOR
// port and reject clean frames whose XOR is non-zero.
module maple_rx_deserializer
  import maple_pkg::*;
#(
  parameter int MAX_BYTES      = MAPLE_MAX_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = MAPLE_TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = MAPLE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdcka_in,
  input  logic             sdckb_in,
  input  logic             sdcka_negedge,
  input  logic             sdckb_negedge,
  input  logic             frame_start,
  input  logic             end_frame,
  input  logic             end_frame_error,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_count,
  output logic             frame_done,
  output logic             frame_error,
  output logic             busy
`ifdef MAPLE_RX_LRC_CHECK_EN
  ,
  output logic [7:0]       rx_lrc
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BYTES);

  maple_rx_state_e  state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_error_q, frame_error_d;
  logic             busy_q, busy_d;
  logic             asm_clear_s, asm_enable_s;
  logic             bit_accept_s, byte_ready_s;
  logic [7:0]       byte_data_s;
  logic             clean_ok_s;
`ifdef MAPLE_RX_LRC_CHECK_EN
  logic [7:0]       lrc_q, lrc_d;
`endif

  // A terminating input in RECV wins over any sampling edge that cycle
  assign asm_clear_s  = (state_q == MAPLE_RX_IDLE) && frame_start;
  assign asm_enable_s = (state_q == MAPLE_RX_RECV) && !frame_start && !end_frame && !end_frame_error;

  maple_byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (asm_clear_s),
    .enable        (asm_enable_s),
    .sdcka_in      (sdcka_in),
    .sdckb_in      (sdckb_in),
    .sdcka_negedge (sdcka_negedge),
    .sdckb_negedge (sdckb_negedge),
    .bit_accept    (bit_accept_s),
    .byte_ready    (byte_ready_s),
    .byte_data     (byte_data_s)
  );

  // An empty frame (or one with a bad checksum) is never reported as clean
`ifdef MAPLE_RX_LRC_CHECK_EN
  assign clean_ok_s = (rx_count_q != {CNT_W{1'b0}}) && (lrc_q == 8'h00);
`else
  assign clean_ok_s = (rx_count_q != {CNT_W{1'b0}});
`endif

  // Next-state, timer, byte counter and output pulse computation
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rx_count_d    = rx_count_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
`ifdef MAPLE_RX_LRC_CHECK_EN
    lrc_d         = lrc_q;
`endif
    case (state_q)
      MAPLE_RX_IDLE: begin
        if (frame_start) begin
          state_d    = MAPLE_RX_RECV;
          timer_d    = {TMR_W{1'b0}};
          rx_count_d = {CNT_W{1'b0}};
`ifdef MAPLE_RX_LRC_CHECK_EN
          lrc_d      = 8'h00;
`endif
        end else begin
          state_d = MAPLE_RX_IDLE;
        end
      end
      MAPLE_RX_RECV: begin
        if (frame_start || end_frame_error) begin
          state_d       = MAPLE_RX_DONE;
          frame_error_d = 1'b1;
        end else if (end_frame) begin
          state_d       = MAPLE_RX_DONE;
          frame_done_d  = clean_ok_s;
          frame_error_d = !clean_ok_s;
        end else if (byte_ready_s) begin
          timer_d = {TMR_W{1'b0}};
          if (rx_count_q == CNT_MAX) begin
            state_d       = MAPLE_RX_DONE;
            frame_error_d = 1'b1;
          end else begin
            rx_data_d  = byte_data_s;
            rx_valid_d = 1'b1;
            rx_count_d = rx_count_q + CNT_W'(1);
`ifdef MAPLE_RX_LRC_CHECK_EN
            lrc_d      = maple_lrc_next(lrc_q, byte_data_s);
`endif
          end
        end else if (bit_accept_s) begin
          timer_d = {TMR_W{1'b0}};
        end else if (timer_q == TMR_LIMIT) begin
          state_d       = MAPLE_RX_DONE;
          frame_error_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      MAPLE_RX_DONE: state_d = MAPLE_RX_IDLE;
      default:       state_d = MAPLE_RX_IDLE;
    endcase
    busy_d = (state_d == MAPLE_RX_RECV);
  end

  // State and registered outputs, synchronous reset drops any partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MAPLE_RX_IDLE;
      timer_q       <= {TMR_W{1'b0}};
      rx_count_q    <= {CNT_W{1'b0}};
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rx_count_q    <= rx_count_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

`ifdef MAPLE_RX_LRC_CHECK_EN
  // Running XOR of emitted bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      lrc_q <= 8'h00;
    end else begin
      lrc_q <= lrc_d;
    end
  end

  assign rx_lrc = lrc_q;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_count    = rx_count_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule
